// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types and default parameters for the TRNG entropy source
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } ro_state_t;

  localparam int DEF_NUM_RO        = 8;
  localparam int DEF_STAGES        = 13;
  localparam int DEF_WARMUP_CYCLES = 256;
  localparam int DEF_RCT_CUTOFF    = 32;

endpackage

// File: rtl/ro_cell.sv
// rtl/ro_cell.sv - gated ring oscillator with selectable longer loop
module ro_cell #(
  parameter int STAGES = 13
) (
  input  logic en,
  input  logic ctrl,
  output logic out
);

  (* dont_touch = "true" *) logic [STAGES+1:0] w_stage;
  (* dont_touch = "true" *) logic              w_fb;

  // ctrl taps two stages further down so the loop stays an odd inversion count
  assign w_fb       = ctrl ? w_stage[STAGES+1] : w_stage[STAGES-1];
  assign w_stage[0] = ~(en & w_fb);

  for (genvar g = 1; g < STAGES + 2; g++) begin : g_stage
    assign w_stage[g] = ~w_stage[g-1];
  end

  assign out = w_stage[STAGES-1];

endmodule

// File: rtl/ro_sampler_bank.sv
// rtl/ro_sampler_bank.sv - ring-oscillator bank sampler with warm-up and repetition-count health test
module ro_sampler_bank
  import trng_pkg::*;
#(
  parameter int NUM_RO        = DEF_NUM_RO,
  parameter int STAGES        = DEF_STAGES,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              test_mode,
  input  logic [NUM_RO-1:0] test_bits,
  input  logic [NUM_RO-1:0] ro_ctrl,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              health_fail,
  output logic [1:0]        state_o
);

  localparam int CW = $clog2(WARMUP_CYCLES + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);
  localparam logic [RW-1:0] RCT_MAX   = RW'(RCT_CUTOFF);

  ro_state_t         r_state;
  logic [NUM_RO-1:0] r_sync1;
  logic [NUM_RO-1:0] r_sync2;
  logic [CW-1:0]     r_warm_cnt;
  logic [RW-1:0]     r_rct_cnt;
  logic              r_last;
  logic              r_bit_out;
  logic              r_valid;
  logic              r_health_fail;

  logic              w_ring_en;
  logic [NUM_RO-1:0] w_ro_out;
  logic [NUM_RO-1:0] w_src;
  logic              w_raw;

  // Rings only oscillate while actively producing; test mode keeps them quiet too
  assign w_ring_en = en & ~test_mode & ((r_state == ST_WARMUP) | (r_state == ST_RUN));

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
    (* dont_touch = "true" *) ro_cell #(
      .STAGES (STAGES)
    ) u_ro_cell (
      .en   (w_ring_en),
      .ctrl (ro_ctrl[i]),
      .out  (w_ro_out[i])
    );
  end

  assign w_src = test_mode ? test_bits : w_ro_out;
  assign w_raw = ^r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_warm_cnt    <= '0;
      r_rct_cnt     <= '0;
      r_last        <= 1'b0;
      r_bit_out     <= 1'b0;
      r_valid       <= 1'b0;
      r_health_fail <= 1'b0;
    end else begin
      r_sync1 <= w_src;
      r_sync2 <= r_sync1;
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (en) begin
            r_warm_cnt <= '0;
            r_state    <= ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (!en) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end else if (r_warm_cnt == WARM_LAST) begin
            r_state   <= ST_RUN;
            r_rct_cnt <= '0;
            r_last    <= 1'b0;
          end else begin
            r_warm_cnt <= r_warm_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          // A health trip takes priority over en falling
          if (r_rct_cnt == RCT_MAX) begin
            r_state       <= ST_FAIL;
            r_valid       <= 1'b0;
            r_health_fail <= 1'b1;
          end else if (!en) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end else begin
            if (!r_valid || bit_ready) begin
              r_bit_out <= w_raw;
              r_valid   <= 1'b1;
            end
            // rct_cnt of zero marks the first bit after entering RUN
            if ((r_rct_cnt == '0) || (w_raw != r_last)) begin
              r_rct_cnt <= RW'(1);
              r_last    <= w_raw;
            end else if (r_rct_cnt != RCT_MAX) begin
              r_rct_cnt <= r_rct_cnt + RW'(1);
            end
          end
        end
        ST_FAIL: begin
          r_valid       <= 1'b0;
          r_health_fail <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bit_out     = r_bit_out;
  assign bit_valid   = r_valid;
  assign health_fail = r_health_fail;
  assign state_o     = r_state;

endmodule

// File: tb/tb_ro_sampler_bank.sv
// tb/tb_ro_sampler_bank.sv - directed self-checking bench for ro_sampler_bank
module tb_ro_sampler_bank;

  localparam int NRO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           test_mode;
  logic [NRO-1:0] test_bits;
  logic [NRO-1:0] ro_ctrl;
  logic           bit_out;
  logic           bit_valid;
  logic           bit_ready;
  logic           health_fail;
  logic [1:0]     state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ro_sampler_bank #(
    .NUM_RO        (NRO),
    .STAGES        (3),
    .WARMUP_CYCLES (8),
    .RCT_CUTOFF    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .test_mode   (test_mode),
    .test_bits   (test_bits),
    .ro_ctrl     (ro_ctrl),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .health_fail (health_fail),
    .state_o     (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive test_bits for the next edge, then advance to just after that edge
  task automatic cyc(input logic [NRO-1:0] tb);
    test_bits = tb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    test_mode = 1'b1;
    bit_ready = 1'b1;
    ro_ctrl   = 4'b0101;
    test_bits = '0;
    cyc(4'b0000);
    cyc(4'b0000);
    chk("reset_bit_out", bit_out, 0);
    chk("reset_valid", bit_valid, 0);
    chk("reset_health", health_fail, 0);
    chk("reset_state", state_o, 0);

    rst = 1'b0;
    cyc(4'b0000);
    chk("idle_without_en", state_o, 0);

    // Warm-up then alternating raw stream
    en = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      cyc((j % 2 == 0) ? 4'b0001 : 4'b0000);
      if (j == 0) chk("enter_warmup", state_o, 1);
      if (j == 7) chk("still_warmup", state_o, 1);
      if (j == 8) begin
        chk("enter_run", state_o, 2);
        chk("valid_low_at_run_entry", bit_valid, 0);
      end
      if (j >= 9) begin
        chk("toggle_valid", bit_valid, 1);
        chk("toggle_bit", bit_out, (j % 2 == 0) ? 1 : 0);
      end
      if (j == 12) chk("toggle_no_health", health_fail, 0);
    end

    // XOR parity
    cyc(4'b0111);
    cyc(4'b0111);
    cyc(4'b0111);
    chk("parity_0111", bit_out, 1);
    cyc(4'b0110);
    cyc(4'b0111);
    cyc(4'b0110);
    chk("parity_alt_0", bit_out, 0);
    cyc(4'b0111);
    chk("parity_alt_1", bit_out, 1);

    // Backpressure: hold for five stalled edges, then load raw from two edges back
    bit_ready = 1'b0;
    cyc(4'b0111); chk("stall_hold_0", bit_out, 1);
    cyc(4'b0110); chk("stall_hold_1", bit_out, 1);
    cyc(4'b0111); chk("stall_hold_2", bit_out, 1);
    cyc(4'b0110); chk("stall_hold_3", bit_out, 1);
    cyc(4'b0111); chk("stall_hold_4", bit_out, 1);
    chk("stall_valid", bit_valid, 1);
    bit_ready = 1'b1;
    cyc(4'b0110);
    chk("stall_release_bit", bit_out, 0);
    chk("stall_release_valid", bit_valid, 1);

    // Reset mid-stream
    rst = 1'b1;
    cyc(4'b0110);
    chk("midrst_bit_out", bit_out, 0);
    chk("midrst_valid", bit_valid, 0);
    chk("midrst_health", health_fail, 0);
    chk("midrst_state", state_o, 0);

    // en drop at warm-up count 3, then full restart
    rst = 1'b0;
    en  = 1'b1;
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'b0001);
    chk("warm_count3_state", state_o, 1);
    en = 1'b0;
    cyc(4'b0001);
    chk("drop_to_idle", state_o, 0);
    chk("drop_valid", bit_valid, 0);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(4'b0001);
      chk("rewarm_valid_low", bit_valid, 0);
      if (i == 7) chk("rewarm_full_length", state_o, 1);
      if (i == 8) chk("rewarm_run", state_o, 2);
    end

    // Constant raw=1 trips the health test 32 edges after the first bit
    cyc(4'b0001);
    chk("first_bit_valid", bit_valid, 1);
    chk("first_bit_value", bit_out, 1);
    for (int i = 0; i < 31; i++) begin
      cyc(4'b0001);
      if (i == 30) begin
        chk("pre_trip_state", state_o, 2);
        chk("pre_trip_valid", bit_valid, 1);
        chk("pre_trip_health", health_fail, 0);
      end
    end
    cyc(4'b0001);
    chk("trip_health", health_fail, 1);
    chk("trip_valid", bit_valid, 0);
    chk("trip_state", state_o, 3);

    en = 1'b0;
    cyc(4'b0001);
    en = 1'b1;
    cyc(4'b0001);
    cyc(4'b0001);
    chk("fail_sticky_state", state_o, 3);
    chk("fail_sticky_health", health_fail, 1);
    chk("fail_sticky_valid", bit_valid, 0);

    rst = 1'b1;
    cyc(4'b0001);
    chk("fail_rst_health", health_fail, 0);
    chk("fail_rst_valid", bit_valid, 0);
    chk("fail_rst_state", state_o, 0);
    chk("fail_rst_bit_out", bit_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
